stg4mo_ctrl: RTL and testbench
==============================

// Module: stg4mo_ctrl
// PURPOSE
//  Sequencer for the stage-4 memory-operation (MO) slot. Accepts one load/store from stage 3,
//  drives a req/ack data-memory port, stalls the pipeline while the access is outstanding,
//  and returns load data plus GP target to the stg4 result path. One access in flight max.
// PARAMETERS
//  ADDR_W    24   memory address width (matches `SIZE_ADDR)
//  DATA_W    24   data width (matches `SIZE_DATA)
//  TGT_W     4    GP target index width (matches `SIZE_TGT_GP)
//  TMO_CYC   255  cycles without ack before abort (only with STG4MO_TIMEOUT_EN); range 1..2^16-1
// PORTS
//  iw_clk        in   1       clock; the block has one clock
//  iw_rst_n      in   1       reset: asynchronous, active-low
//  iw_flush      in   1       pipeline flush; kills the current/pending MO
//  iw_mo_valid   in   1       stage-3 slot holds a candidate MO
//  iw_mo_ld      in   1       MO is a load
//  iw_mo_st      in   1       MO is a store
//  iw_mo_addr    in   ADDR_W  access address
//  iw_mo_wdata   in   DATA_W  store data
//  iw_mo_tgt_gp  in   TGT_W   load destination register
//  ow_stall      out  1       hold stages 1..3 and the stg4 latch
//  ow_mem_req    out  1       memory request
//  ow_mem_we     out  1       1 = write
//  ow_mem_addr   out  ADDR_W  memory address
//  ow_mem_wdata  out  DATA_W  memory write data
//  iw_mem_ack    in   1       access complete; rdata valid this cycle for reads
//  iw_mem_rdata  in   DATA_W  read data
//  ow_rd_valid   out  1       1-cycle pulse: load data ready
//  ow_rd_data    out  DATA_W  load data
//  ow_rd_tgt_gp  out  TGT_W   load destination register
//  ow_illegal    out  1       1-cycle pulse: ld and st both set; MO not issued
//  ow_mo_err     out  1       1-cycle pulse: timeout abort (0 without STG4MO_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (iw_rst_n low, any time, async): state IDLE; all outputs and captured regs 0.
//    A request in flight is dropped; memory is reset in the same domain.
//  - States: IDLE, ACCESS (req high, result wanted), KILLED (req high, result discarded).
//  - Accept occurs in IDLE when iw_mo_valid & (ld ^ st) & !iw_flush.
//    On accept, addr/wdata/we/tgt are captured and the next state is ACCESS.
//    ld & st together: no accept, ow_illegal pulses next cycle. Flush wins over valid.
//  - ow_mem_req/we/addr/wdata are registered and high/stable for every cycle in ACCESS or KILLED.
//  - ACCESS: iw_mem_ack -> IDLE. For a load, ow_rd_data/ow_rd_tgt_gp are registered and
//    ow_rd_valid=1 for exactly the next cycle. Store: no rd_valid.
//  - ACCESS: iw_flush & !iw_mem_ack -> KILLED. Flush and ack in the same cycle: ack completes,
//    but rd_valid is suppressed.
//  - KILLED: the request cannot be aborted, so hold req until ack -> IDLE. No rd_valid.
//  - ow_stall = (state != IDLE), combinational from the state register. It is 0 on the accept cycle.
//  - Latency: accept edge N -> req during N+1..M (M = ack cycle) -> rd_valid and stall low at M+1.
//    A zero-wait memory gives 1 stall cycle. A new accept is legal in the rd_valid cycle.
//  - ow_rd_data holds its value between pulses. Outputs never show X after reset.
// CONFIGURATION
//  STG4MO_TIMEOUT_EN defined:
//    - A 16-bit counter clears on entry to ACCESS/KILLED and increments each cycle without ack.
//    - At count == TMO_CYC-1 with no ack: next state IDLE, req drops, ow_mo_err pulses 1 cycle,
//      no rd_valid.
//    - Ack on the same cycle wins.
//  Undefined: no counter; the block waits indefinitely; ow_mo_err tied 0.
// STRUCTURE
//  - Widths come from src/sizes.vh (SIZE_ADDR/DATA/TGT_GP).
//  - State encodings (MO_S_IDLE=2'd0, MO_S_ACCESS=2'd1, MO_S_KILLED=2'd2) go in shared
//    header src/mo_ctrl.vh for the hazard unit and the bench.
//  - Sub-module stg4mo_tmo: timeout counter (clr, inc, hit). Instantiated only under
//    STG4MO_TIMEOUT_EN.
// TESTING
//  1. Load to 0x000123, ack 3 cycles after req, rdata 0xABCDEF, tgt 5
//     -> stall 3 cycles; rd_valid 1 cycle with 0xABCDEF, tgt 5.
//  2. Store 0x00FFFF to 0x000010, ack same cycle as req
//     -> we=1 for 1 req cycle; stall 1 cycle; no rd_valid.
//  3. Back-to-back loads, 2nd valid in rd_valid cycle, zero-wait acks
//     -> 2nd accepted immediately; rd_valid pulses 2 cycles apart.
//  4. Load, flush 1 cycle after req, ack 4 cycles later -> KILLED; req held to ack; no rd_valid.
//     Flush + ack same cycle -> no rd_valid.
//  5. ld=st=1 valid -> ow_illegal 1 pulse, no req. Reset low mid-ACCESS -> req/stall 0 immediately.
//  6. STG4MO_TIMEOUT_EN, TMO_CYC=8, never ack -> req for 8 cycles; ow_mo_err pulses; IDLE.
//     Without the macro -> req held; ow_mo_err stays 0.

Source files
------------

// File: rtl/stg4mo_ctrl_pkg.sv
// Shared types and widths for the stage-4 memory-operation sequencer.
// Build option STG4MO_TIMEOUT_EN adds a no-ack timeout abort.
package stg4mo_ctrl_pkg;

  localparam int unsigned ADDR_W      = 24;
  localparam int unsigned DATA_W      = 24;
  localparam int unsigned TGT_W       = 4;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned TMO_CYC_DEF = 255;

  typedef enum logic [1:0] {
    MO_S_IDLE   = 2'd0,
    MO_S_ACCESS = 2'd1,
    MO_S_KILLED = 2'd2
  } mo_state_t;

  // Captured memory operation, held for the whole access
  typedef struct packed {
    logic              ld;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TGT_W-1:0]  tgt;
  } mo_req_t;

  // Load result returned to the stg4 result path
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TGT_W-1:0]  tgt;
  } mo_rd_t;

endpackage

// File: rtl/stg4mo_ctrl_if.sv
// Stage-3 MO slot, data-memory port and load-result bundle of the MO sequencer.
// master = sequencer side, slave = pipeline/memory side.
interface stg4mo_ctrl_if;
  import stg4mo_ctrl_pkg::*;

  logic              iw_flush;
  logic              iw_mo_valid;
  logic              iw_mo_ld;
  logic              iw_mo_st;
  logic [ADDR_W-1:0] iw_mo_addr;
  logic [DATA_W-1:0] iw_mo_wdata;
  logic [TGT_W-1:0]  iw_mo_tgt_gp;
  logic              ow_stall;
  logic              ow_mem_req;
  logic              ow_mem_we;
  logic [ADDR_W-1:0] ow_mem_addr;
  logic [DATA_W-1:0] ow_mem_wdata;
  logic              iw_mem_ack;
  logic [DATA_W-1:0] iw_mem_rdata;
  logic              ow_rd_valid;
  logic [DATA_W-1:0] ow_rd_data;
  logic [TGT_W-1:0]  ow_rd_tgt_gp;
  logic              ow_illegal;
  logic              ow_mo_err;

  modport master (
    input  iw_flush, iw_mo_valid, iw_mo_ld, iw_mo_st, iw_mo_addr, iw_mo_wdata,
           iw_mo_tgt_gp, iw_mem_ack, iw_mem_rdata,
    output ow_stall, ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
           ow_rd_valid, ow_rd_data, ow_rd_tgt_gp, ow_illegal, ow_mo_err
  );

  modport slave (
    output iw_flush, iw_mo_valid, iw_mo_ld, iw_mo_st, iw_mo_addr, iw_mo_wdata,
           iw_mo_tgt_gp, iw_mem_ack, iw_mem_rdata,
    input  ow_stall, ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
           ow_rd_valid, ow_rd_data, ow_rd_tgt_gp, ow_illegal, ow_mo_err
  );

endinterface

// File: rtl/stg4mo_tmo.sv
// No-ack timeout counter for the MO sequencer; hit_c flags the last allowed wait cycle.
// Only instantiated when STG4MO_TIMEOUT_EN is defined.
module stg4mo_tmo
  import stg4mo_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic iw_clk,
  input  logic iw_rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n)  cnt_q <= '0;
    else if (clr)   cnt_q <= '0;
    else if (inc)   cnt_q <= cnt_q + CNT_W'(1);
  end

  assign hit_c = (cnt_q == LAST);

endmodule

// File: rtl/stg4mo_ctrl.sv
// Stage-4 MO sequencer: one load/store in flight on a req/ack data-memory port.
// STG4MO_TIMEOUT_EN adds an abort after TMO_CYC cycles without ack (ow_mo_err).
module stg4mo_ctrl
  import stg4mo_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic          iw_clk,
  input  logic          iw_rst_n,
  stg4mo_ctrl_if.master bus
);

  mo_state_t state_q, state_d;
  mo_req_t   mo_q, mo_d;
  mo_rd_t    rd_q, rd_d;
  logic      req_q, req_d;
  logic      rd_valid_q, rd_valid_d;
  logic      illegal_q, illegal_d;
  logic      mo_err_q, mo_err_d;
  logic      tmo_clr_c, tmo_inc_c, tmo_hit_c;
  logic      accept_c;

  assign accept_c = bus.iw_mo_valid & (bus.iw_mo_ld ^ bus.iw_mo_st) & ~bus.iw_flush;

`ifdef STG4MO_TIMEOUT_EN
  stg4mo_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .iw_clk   (iw_clk),
    .iw_rst_n (iw_rst_n),
    .clr      (tmo_clr_c),
    .inc      (tmo_inc_c),
    .hit_c    (tmo_hit_c)
  );
`else
  logic unused_tmo;
  assign tmo_hit_c  = 1'b0;
  assign unused_tmo = ^{tmo_clr_c, tmo_inc_c, CNT_W'(TMO_CYC)};
`endif

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q    <= MO_S_IDLE;
      mo_q       <= '0;
      rd_q       <= '0;
      req_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      mo_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mo_q       <= mo_d;
      rd_q       <= rd_d;
      req_q      <= req_d;
      rd_valid_q <= rd_valid_d;
      illegal_q  <= illegal_d;
      mo_err_q   <= mo_err_d;
    end
  end

  // Priority while waiting: ack, then timeout, then flush.
  always_comb begin
    state_d    = state_q;
    mo_d       = mo_q;
    rd_d       = rd_q;
    req_d      = req_q;
    rd_valid_d = 1'b0;
    illegal_d  = 1'b0;
    mo_err_d   = 1'b0;
    tmo_clr_c  = 1'b0;
    tmo_inc_c  = 1'b0;
    case (state_q)
      MO_S_IDLE: begin
        if (accept_c) begin
          state_d    = MO_S_ACCESS;
          req_d      = 1'b1;
          tmo_clr_c  = 1'b1;
          mo_d.ld    = bus.iw_mo_ld;
          mo_d.we    = bus.iw_mo_st;
          mo_d.addr  = bus.iw_mo_addr;
          mo_d.wdata = bus.iw_mo_wdata;
          mo_d.tgt   = bus.iw_mo_tgt_gp;
        end else if (bus.iw_mo_valid & bus.iw_mo_ld & bus.iw_mo_st & ~bus.iw_flush) begin
          illegal_d = 1'b1;
        end
      end
      MO_S_ACCESS: begin
        if (bus.iw_mem_ack) begin
          state_d = MO_S_IDLE;
          req_d   = 1'b0;
          mo_d.we = 1'b0;
          if (mo_q.ld & ~bus.iw_flush) begin
            rd_valid_d = 1'b1;
            rd_d.data  = bus.iw_mem_rdata;
            rd_d.tgt   = mo_q.tgt;
          end
        end else if (tmo_hit_c) begin
          state_d  = MO_S_IDLE;
          req_d    = 1'b0;
          mo_d.we  = 1'b0;
          mo_err_d = 1'b1;
        end else if (bus.iw_flush) begin
          state_d   = MO_S_KILLED;
          tmo_clr_c = 1'b1;
        end else begin
          tmo_inc_c = 1'b1;
        end
      end
      MO_S_KILLED: begin
        if (bus.iw_mem_ack) begin
          state_d = MO_S_IDLE;
          req_d   = 1'b0;
          mo_d.we = 1'b0;
        end else if (tmo_hit_c) begin
          state_d  = MO_S_IDLE;
          req_d    = 1'b0;
          mo_d.we  = 1'b0;
          mo_err_d = 1'b1;
        end else begin
          tmo_inc_c = 1'b1;
        end
      end
      default: begin
        state_d = MO_S_IDLE;
        req_d   = 1'b0;
        mo_d.we = 1'b0;
      end
    endcase
  end

  assign bus.ow_stall     = (state_q != MO_S_IDLE);
  assign bus.ow_mem_req   = req_q;
  assign bus.ow_mem_we    = mo_q.we;
  assign bus.ow_mem_addr  = mo_q.addr;
  assign bus.ow_mem_wdata = mo_q.wdata;
  assign bus.ow_rd_valid  = rd_valid_q;
  assign bus.ow_rd_data   = rd_q.data;
  assign bus.ow_rd_tgt_gp = rd_q.tgt;
  assign bus.ow_illegal   = illegal_q;
  assign bus.ow_mo_err    = mo_err_q;

endmodule

// File: tb/tb_stg4mo_ctrl.sv
// Directed bench for stg4mo_ctrl; inputs change 1 ns after the rising edge, outputs sampled there.
// Timeout expectations follow STG4MO_TIMEOUT_EN with TMO_CYC = 8.
module tb_stg4mo_ctrl;

  logic iw_clk;
  logic iw_rst_n;
  int   tests_run;
  int   tests_failed;

  stg4mo_ctrl_if bus();

  stg4mo_ctrl #(.TMO_CYC(8)) dut (
    .iw_clk   (iw_clk),
    .iw_rst_n (iw_rst_n),
    .bus      (bus.master)
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  task automatic tick;
    @(posedge iw_clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.iw_flush     = 1'b0;
    bus.iw_mo_valid  = 1'b0;
    bus.iw_mo_ld     = 1'b0;
    bus.iw_mo_st     = 1'b0;
    bus.iw_mo_addr   = '0;
    bus.iw_mo_wdata  = '0;
    bus.iw_mo_tgt_gp = '0;
    bus.iw_mem_ack   = 1'b0;
    bus.iw_mem_rdata = '0;
  endtask

  // Present one MO for a single edge, then withdraw it.
  task automatic issue(input logic ld, input logic st, input logic [23:0] addr,
                       input logic [23:0] wdata, input logic [3:0] tgt);
    bus.iw_mo_valid  = 1'b1;
    bus.iw_mo_ld     = ld;
    bus.iw_mo_st     = st;
    bus.iw_mo_addr   = addr;
    bus.iw_mo_wdata  = wdata;
    bus.iw_mo_tgt_gp = tgt;
    tick();
    bus.iw_mo_valid  = 1'b0;
    bus.iw_mo_ld     = 1'b0;
    bus.iw_mo_st     = 1'b0;
  endtask

  task automatic test_reset;
    iw_rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    tests_run++;
    if ({bus.ow_stall, bus.ow_mem_req, bus.ow_mem_we, bus.ow_rd_valid, bus.ow_illegal, bus.ow_mo_err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000000",
               {bus.ow_stall, bus.ow_mem_req, bus.ow_mem_we, bus.ow_rd_valid, bus.ow_illegal, bus.ow_mo_err});
    end
    tests_run++;
    if ({bus.ow_mem_addr, bus.ow_mem_wdata, bus.ow_rd_data, bus.ow_rd_tgt_gp} !== 76'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h want 0", {bus.ow_mem_addr, bus.ow_mem_wdata, bus.ow_rd_data, bus.ow_rd_tgt_gp});
    end
    @(negedge iw_clk);
    iw_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load;
    int stall_n;
    stall_n = 0;
    issue(1'b1, 1'b0, 24'h000123, 24'h0, 4'd5);
    tests_run++;
    if ({bus.ow_mem_req, bus.ow_mem_we, bus.ow_mem_addr} !== {1'b1, 1'b0, 24'h000123}) begin
      tests_failed++;
      $display("FAIL load_req: got req=%b we=%b addr=%h want 1 0 000123", bus.ow_mem_req, bus.ow_mem_we, bus.ow_mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.ow_stall) stall_n++;
      if (i == 2) begin
        bus.iw_mem_ack   = 1'b1;
        bus.iw_mem_rdata = 24'hABCDEF;
      end
      tick();
    end
    bus.iw_mem_ack = 1'b0;
    tests_run++;
    if (stall_n != 3) begin
      tests_failed++;
      $display("FAIL load_stall_cycles: got %0d want 3", stall_n);
    end
    tests_run++;
    if ({bus.ow_rd_valid, bus.ow_rd_data, bus.ow_rd_tgt_gp, bus.ow_stall, bus.ow_mem_req} !== {1'b1, 24'hABCDEF, 4'd5, 2'b00}) begin
      tests_failed++;
      $display("FAIL load_result: got v=%b d=%h t=%0d stall=%b req=%b want 1 abcdef 5 0 0",
               bus.ow_rd_valid, bus.ow_rd_data, bus.ow_rd_tgt_gp, bus.ow_stall, bus.ow_mem_req);
    end
    tick();
    tests_run++;
    if ({bus.ow_rd_valid, bus.ow_rd_data} !== {1'b0, 24'hABCDEF}) begin
      tests_failed++;
      $display("FAIL load_pulse_hold: got v=%b d=%h want 0 abcdef", bus.ow_rd_valid, bus.ow_rd_data);
    end
  endtask

  task automatic test_store;
    issue(1'b0, 1'b1, 24'h000010, 24'h00FFFF, 4'd0);
    tests_run++;
    if ({bus.ow_mem_req, bus.ow_mem_we, bus.ow_stall, bus.ow_mem_addr, bus.ow_mem_wdata} !== {3'b111, 24'h000010, 24'h00FFFF}) begin
      tests_failed++;
      $display("FAIL store_req: got req=%b we=%b stall=%b a=%h d=%h want 1 1 1 000010 00ffff",
               bus.ow_mem_req, bus.ow_mem_we, bus.ow_stall, bus.ow_mem_addr, bus.ow_mem_wdata);
    end
    bus.iw_mem_ack = 1'b1;
    tick();
    bus.iw_mem_ack = 1'b0;
    tests_run++;
    if ({bus.ow_mem_req, bus.ow_mem_we, bus.ow_stall, bus.ow_rd_valid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL store_done: got req=%b we=%b stall=%b rdv=%b want 0 0 0 0",
               bus.ow_mem_req, bus.ow_mem_we, bus.ow_stall, bus.ow_rd_valid);
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 1'b0, 24'h000020, 24'h0, 4'd1);
    bus.iw_mem_ack   = 1'b1;
    bus.iw_mem_rdata = 24'h111111;
    tick();
    bus.iw_mem_ack = 1'b0;
    tests_run++;
    if ({bus.ow_rd_valid, bus.ow_rd_data, bus.ow_rd_tgt_gp, bus.ow_stall} !== {1'b1, 24'h111111, 4'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_first: got v=%b d=%h t=%0d stall=%b want 1 111111 1 0",
               bus.ow_rd_valid, bus.ow_rd_data, bus.ow_rd_tgt_gp, bus.ow_stall);
    end
    issue(1'b1, 1'b0, 24'h000021, 24'h0, 4'd2);
    tests_run++;
    if ({bus.ow_mem_req, bus.ow_stall, bus.ow_rd_valid, bus.ow_mem_addr} !== {3'b110, 24'h000021}) begin
      tests_failed++;
      $display("FAIL b2b_second_accept: got req=%b stall=%b v=%b a=%h want 1 1 0 000021",
               bus.ow_mem_req, bus.ow_stall, bus.ow_rd_valid, bus.ow_mem_addr);
    end
    bus.iw_mem_ack   = 1'b1;
    bus.iw_mem_rdata = 24'h222222;
    tick();
    bus.iw_mem_ack = 1'b0;
    tests_run++;
    if ({bus.ow_rd_valid, bus.ow_rd_data, bus.ow_rd_tgt_gp} !== {1'b1, 24'h222222, 4'd2}) begin
      tests_failed++;
      $display("FAIL b2b_second: got v=%b d=%h t=%0d want 1 222222 2", bus.ow_rd_valid, bus.ow_rd_data, bus.ow_rd_tgt_gp);
    end
    tick();
  endtask

  task automatic test_flush;
    int held_n;
    held_n = 0;
    issue(1'b1, 1'b0, 24'h000030, 24'h0, 4'd3);
    tick();
    bus.iw_flush = 1'b1;
    tick();
    bus.iw_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.ow_mem_req && bus.ow_stall && bus.ow_mem_addr == 24'h000030) held_n++;
      tick();
    end
    tests_run++;
    if (held_n != 3) begin
      tests_failed++;
      $display("FAIL flush_req_held: got %0d cycles want 3", held_n);
    end
    bus.iw_mem_ack   = 1'b1;
    bus.iw_mem_rdata = 24'h5A5A5A;
    tick();
    bus.iw_mem_ack = 1'b0;
    tests_run++;
    if ({bus.ow_mem_req, bus.ow_stall, bus.ow_rd_valid, bus.ow_rd_data} !== {3'b000, 24'h222222}) begin
      tests_failed++;
      $display("FAIL flush_killed_done: got req=%b stall=%b v=%b d=%h want 0 0 0 222222",
               bus.ow_mem_req, bus.ow_stall, bus.ow_rd_valid, bus.ow_rd_data);
    end
    issue(1'b1, 1'b0, 24'h000031, 24'h0, 4'd4);
    bus.iw_flush     = 1'b1;
    bus.iw_mem_ack   = 1'b1;
    bus.iw_mem_rdata = 24'h777777;
    tick();
    bus.iw_flush   = 1'b0;
    bus.iw_mem_ack = 1'b0;
    tests_run++;
    if ({bus.ow_mem_req, bus.ow_stall, bus.ow_rd_valid, bus.ow_rd_data} !== {3'b000, 24'h222222}) begin
      tests_failed++;
      $display("FAIL flush_with_ack: got req=%b stall=%b v=%b d=%h want 0 0 0 222222",
               bus.ow_mem_req, bus.ow_stall, bus.ow_rd_valid, bus.ow_rd_data);
    end
  endtask

  task automatic test_illegal_and_reset;
    issue(1'b1, 1'b1, 24'h000040, 24'h0, 4'd6);
    tests_run++;
    if ({bus.ow_illegal, bus.ow_mem_req, bus.ow_stall} !== 3'b100) begin
      tests_failed++;
      $display("FAIL illegal_pulse: got ill=%b req=%b stall=%b want 1 0 0", bus.ow_illegal, bus.ow_mem_req, bus.ow_stall);
    end
    tick();
    tests_run++;
    if (bus.ow_illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_one_cycle: got %b want 0", bus.ow_illegal);
    end
    bus.iw_flush = 1'b1;
    issue(1'b1, 1'b0, 24'h000050, 24'h0, 4'd7);
    bus.iw_flush = 1'b0;
    tests_run++;
    if ({bus.ow_mem_req, bus.ow_stall} !== 2'b00) begin
      tests_failed++;
      $display("FAIL flush_beats_valid: got req=%b stall=%b want 0 0", bus.ow_mem_req, bus.ow_stall);
    end
    issue(1'b1, 1'b0, 24'h000060, 24'h0, 4'd8);
    #2;
    iw_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.ow_mem_req, bus.ow_stall, bus.ow_rd_data, bus.ow_mem_addr} !== {2'b00, 24'h0, 24'h0}) begin
      tests_failed++;
      $display("FAIL async_reset: got req=%b stall=%b d=%h a=%h want 0 0 0 0",
               bus.ow_mem_req, bus.ow_stall, bus.ow_rd_data, bus.ow_mem_addr);
    end
    #3;
    iw_rst_n = 1'b1;
    tick();
    tests_run++;
    if ({bus.ow_mem_req, bus.ow_stall} !== 2'b00) begin
      tests_failed++;
      $display("FAIL after_reset_idle: got req=%b stall=%b want 0 0", bus.ow_mem_req, bus.ow_stall);
    end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    issue(1'b1, 1'b0, 24'h000070, 24'h0, 4'd9);
`ifdef STG4MO_TIMEOUT_EN
    while (bus.ow_mem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    tests_run++;
    if (n != 8) begin
      tests_failed++;
      $display("FAIL tmo_req_cycles: got %0d want 8", n);
    end
    tests_run++;
    if ({bus.ow_mo_err, bus.ow_stall, bus.ow_rd_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL tmo_abort: got err=%b stall=%b v=%b want 1 0 0", bus.ow_mo_err, bus.ow_stall, bus.ow_rd_valid);
    end
    tick();
    tests_run++;
    if (bus.ow_mo_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_err_one_cycle: got %b want 0", bus.ow_mo_err);
    end
`else
    for (int i = 0; i < 20; i++) begin
      if (bus.ow_mem_req !== 1'b1 || bus.ow_mo_err !== 1'b0) n++;
      tick();
    end
    tests_run++;
    if (n != 0) begin
      tests_failed++;
      $display("FAIL no_tmo_hold: got %0d bad cycles want 0", n);
    end
    bus.iw_mem_ack = 1'b1;
    tick();
    bus.iw_mem_ack = 1'b0;
    tests_run++;
    if ({bus.ow_mem_req, bus.ow_mo_err, bus.ow_rd_valid} !== 3'b001) begin
      tests_failed++;
      $display("FAIL no_tmo_late_ack: got req=%b err=%b v=%b want 0 0 1", bus.ow_mem_req, bus.ow_mo_err, bus.ow_rd_valid);
    end
`endif
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_flush();
    test_illegal_and_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
